axi_burst_master: RTL and testbench
===================================

# axi_burst_master

Bridges the core's cache-line memory requests (start read / start write, 512-bit line, read-last and write-response strobes) to a 64-bit AXI4 master port. Sits directly downstream of the core top level. Refills are issued as 8-beat INCR read bursts and assembled into one line. Dirty-line writebacks are split into 8-beat INCR write bursts. Handles one transaction at a time.

## Interface
Parameters:
- ADDR_WIDTH, 64, byte address width on both sides
- DATA_WIDTH, 64, AXI data bus width
- BLOCK_WIDTH, 512, cache line width; BEATS = BLOCK_WIDTH/DATA_WIDTH = 8
- AXI_ID, 0, constant value driven on o_arid / o_awid (4 bits)

Ports:
- clk  in  1  single clock
- arstn  in  1  synchronous, active-low reset
- i_start_read  in  1  line refill request (level)
- i_start_write  in  1  line writeback request (level)
- i_addr  in  ADDR_WIDTH  line address from data cache
- i_data_block  in  BLOCK_WIDTH  line to write
- o_data_block  out  BLOCK_WIDTH  assembled refill line
- o_read_last  out  1  one-cycle pulse: refill line complete
- o_b_resp  out  1  one-cycle pulse: writeback acknowledged
- o_resp_err  out  1  sticky error flag
- o_arid, o_araddr, o_arlen[7:0], o_arsize[2:0], o_arburst[1:0], o_arvalid  out; i_arready  in
- i_rdata[DATA_WIDTH], i_rresp[1:0], i_rlast, i_rvalid  in; o_rready  out
- o_awid, o_awaddr, o_awlen, o_awsize, o_awburst, o_awvalid  out; i_awready  in
- o_wdata[DATA_WIDTH], o_wstrb[DATA_WIDTH/8], o_wlast, o_wvalid  out; i_wready  in
- i_bresp[1:0], i_bvalid  in; o_bready  out

## Operation
- FSM states: IDLE, AR, R, R_DONE, AW, W, B, B_DONE.
- IDLE:
  - i_start_write high → latch line-aligned address {i_addr[63:6],6'b0} and i_data_block → AW.
  - Otherwise i_start_read high → latch aligned address → AR.
  - When both are high, write wins. Dirty writeback precedes refill.
- AR: o_arvalid=1 until i_arready handshake → R.
- R:
  - o_rready=1. Each i_rvalid beat k (counter 0..7) is written to o_data_block[64k+63:64k].
  - Beat 7 → R_DONE.
- R_DONE: o_read_last=1 for one cycle → IDLE.
- AW: o_awvalid=1 until handshake → W, beat counter cleared.
- W:
  - o_wvalid=1. o_wdata = latched line[64k+63:64k]. o_wlast=1 on beat 7.
  - Counter advances only on i_wready. Beat 7 handshake → B.
- B: o_bready=1. i_bvalid → B_DONE.
- B_DONE: o_b_resp=1 for one cycle → IDLE.
- Constant burst fields: arlen/awlen=7, arsize/awsize=3'b011, arburst/awburst=2'b01 (INCR), wstrb all ones.
- Requester contract: start must deassert in the cycle it samples o_read_last / o_b_resp. Otherwise IDLE accepts it again as a new request.
- Errors: o_resp_err is set and held until reset by any of:
  - rresp≠OKAY
  - bresp≠OKAY
  - i_rlast on beat<7
  - i_rlast missing on beat 7
- Completion is by beat count only. Errors never stall the FSM.
- Start inputs are ignored outside IDLE.
- o_data_block holds the last refill until the next R beat 0 overwrites it.

## Timing
- Reset (arstn low at a clk edge), effective that edge:
  - state→IDLE, all valids/readies 0, pulses 0, o_resp_err 0, o_data_block 0, beat counter 0.
  - Constant fields stay driven.
- Mid-transaction reset abandons the burst with no completion pulse. The interconnect is reset with the core.
- Request sampled at edge N → o_arvalid/o_awvalid high from N+1.
- Address and burst fields are stable while valid is high. Valid never drops before handshake.
- Refill latency with zero-wait slave: AR 1 cycle + 8 R beats + 1 = o_read_last 10 cycles after acceptance. o_data_block is valid in the pulse cycle.
- Writeback with zero-wait slave: AW 1 + W 8 + B ≥1 + 1 pulse.
- R/W beats sustain 1 beat/cycle. Stalls (rvalid or wready low) hold the counter and data.

## Structure
- Package axi_pkg:
  - state enum
  - AXI_BURST_INCR, AXI_RESP_OKAY, AXI_SIZE_8B, BEATS_PER_LINE constants
  - line/beat width localparams, shared with the data cache
- Sub-module axi_line_buffer: 512-bit line register with 3-bit beat index.
  - Write-beat port used for the refill path.
  - Read-beat mux used for the writeback path.
- FSM and channel logic live in axi_burst_master.

## Test plan
- Refill, zero-wait slave, addr 0x8000_1234 → araddr 0x8000_1200, arlen 7; beats 0x00..0x07 land in lanes 0..7; o_read_last pulses 10 cycles after acceptance.
- Writeback of line 0x0706…0100 pattern, wready toggling every other cycle → wdata beats in lane order, wlast only on beat 8, one o_b_resp pulse after bvalid.
- i_start_read and i_start_write high together → AW issued first; read accepted only after o_b_resp and start_write dropped.
- arready delayed 5 cycles, rvalid gaps → araddr/arvalid stable throughout; line correct; single o_read_last.
- rresp=SLVERR on beat 3, and separately rlast on beat 5 → o_resp_err set and held; o_read_last still after beat 8.
- arstn low during R beat 4 → all outputs at reset values next edge; fresh refill afterwards completes normally.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared AXI burst constants, FSM state type and cache-line geometry.
// The data cache uses the same line/beat widths.
package axi_pkg;

    localparam int unsigned LINE_WIDTH     = 512;
    localparam int unsigned BEAT_WIDTH     = 64;
    localparam int unsigned BEATS_PER_LINE = LINE_WIDTH / BEAT_WIDTH;
    localparam int unsigned BEAT_IDX_WIDTH = $clog2(BEATS_PER_LINE);
    localparam int unsigned LINE_BYTES     = LINE_WIDTH / 8;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam logic [2:0] AXI_SIZE_8B    = 3'b011;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AR,
        ST_R,
        ST_R_DONE,
        ST_AW,
        ST_W,
        ST_B,
        ST_B_DONE
    } axi_state_e;

endpackage

// File: rtl/axi_line_buffer.sv
// Cache-line register: whole-line load, single-beat write port and a beat read mux.
// Load takes priority over a beat write in the same cycle.
module axi_line_buffer #(
    parameter int unsigned BLOCK_WIDTH = 512,
    parameter int unsigned DATA_WIDTH  = 64,
    parameter int unsigned IDX_W       = $clog2(BLOCK_WIDTH / DATA_WIDTH)
) (
    input  logic                   clk,
    input  logic                   arstn,
    input  logic                   load_en,
    input  logic [BLOCK_WIDTH-1:0] load_line,
    input  logic                   wr_en,
    input  logic [IDX_W-1:0]       wr_idx,
    input  logic [DATA_WIDTH-1:0]  wr_data,
    input  logic [IDX_W-1:0]       rd_idx,
    output logic [DATA_WIDTH-1:0]  rd_data,
    output logic [BLOCK_WIDTH-1:0] line
);

    always_ff @(posedge clk) begin
        if (!arstn) begin
            line <= '0;
        end else if (load_en) begin
            line <= load_line;
        end else if (wr_en) begin
            line[wr_idx*DATA_WIDTH +: DATA_WIDTH] <= wr_data;
        end
    end

    assign rd_data = line[rd_idx*DATA_WIDTH +: DATA_WIDTH];

endmodule

// File: rtl/axi_burst_master.sv
// Cache-line refill / writeback bridge onto a 64-bit AXI4 master port.
// One transaction at a time; refills and writebacks are single 8-beat INCR bursts.
module axi_burst_master
    import axi_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 64,
    parameter int unsigned DATA_WIDTH  = 64,
    parameter int unsigned BLOCK_WIDTH = 512,
    parameter logic [3:0]  AXI_ID      = 4'd0
) (
    input  logic                      clk,
    input  logic                      arstn,
    input  logic                      i_start_read,
    input  logic                      i_start_write,
    input  logic [ADDR_WIDTH-1:0]     i_addr,
    input  logic [BLOCK_WIDTH-1:0]    i_data_block,
    output logic [BLOCK_WIDTH-1:0]    o_data_block,
    output logic                      o_read_last,
    output logic                      o_b_resp,
    output logic                      o_resp_err,
    output logic [3:0]                o_arid,
    output logic [ADDR_WIDTH-1:0]     o_araddr,
    output logic [7:0]                o_arlen,
    output logic [2:0]                o_arsize,
    output logic [1:0]                o_arburst,
    output logic                      o_arvalid,
    input  logic                      i_arready,
    input  logic [DATA_WIDTH-1:0]     i_rdata,
    input  logic [1:0]                i_rresp,
    input  logic                      i_rlast,
    input  logic                      i_rvalid,
    output logic                      o_rready,
    output logic [3:0]                o_awid,
    output logic [ADDR_WIDTH-1:0]     o_awaddr,
    output logic [7:0]                o_awlen,
    output logic [2:0]                o_awsize,
    output logic [1:0]                o_awburst,
    output logic                      o_awvalid,
    input  logic                      i_awready,
    output logic [DATA_WIDTH-1:0]     o_wdata,
    output logic [DATA_WIDTH/8-1:0]   o_wstrb,
    output logic                      o_wlast,
    output logic                      o_wvalid,
    input  logic                      i_wready,
    input  logic [1:0]                i_bresp,
    input  logic                      i_bvalid,
    output logic                      o_bready
);

    localparam int unsigned BEATS      = BLOCK_WIDTH / DATA_WIDTH;
    localparam int unsigned IDX_W      = $clog2(BEATS);
    localparam int unsigned LINE_BYTES = BLOCK_WIDTH / 8;
    localparam logic [IDX_W-1:0]      LAST_BEAT = IDX_W'(BEATS - 1);
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~ADDR_WIDTH'(LINE_BYTES - 1);

    axi_state_e              state;
    logic [IDX_W-1:0]        beat;
    logic [ADDR_WIDTH-1:0]   addr;

    logic                    refill_wr_c;
    logic                    wb_load_c;
    logic [IDX_W-1:0]        wb_rd_idx_c;
    logic [DATA_WIDTH-1:0]   wb_beat_c;
    logic [DATA_WIDTH-1:0]   refill_beat_unused;
    logic [BLOCK_WIDTH-1:0]  wb_line_unused;

    // Burst shape is fixed; only the address is transaction-specific.
    assign o_arid    = AXI_ID;
    assign o_awid    = AXI_ID;
    assign o_araddr  = addr;
    assign o_awaddr  = addr;
    assign o_arlen   = 8'(BEATS - 1);
    assign o_awlen   = 8'(BEATS - 1);
    assign o_arsize  = AXI_SIZE_8B;
    assign o_awsize  = AXI_SIZE_8B;
    assign o_arburst = AXI_BURST_INCR;
    assign o_awburst = AXI_BURST_INCR;
    assign o_wstrb   = '1;

    // Refill lanes land directly in the output line; writeback line is captured at accept.
    always_comb begin
        refill_wr_c = 1'b0;
        wb_load_c   = 1'b0;
        wb_rd_idx_c = '0;
        if (state == ST_R) begin
            refill_wr_c = i_rvalid;
        end
        if (state == ST_IDLE) begin
            wb_load_c = i_start_write;
        end
        if (state == ST_W) begin
            wb_rd_idx_c = beat + IDX_W'(1);
        end
    end

    axi_line_buffer #(
        .BLOCK_WIDTH (BLOCK_WIDTH),
        .DATA_WIDTH  (DATA_WIDTH),
        .IDX_W       (IDX_W)
    ) u_refill_buf (
        .clk       (clk),
        .arstn     (arstn),
        .load_en   (1'b0),
        .load_line ('0),
        .wr_en     (refill_wr_c),
        .wr_idx    (beat),
        .wr_data   (i_rdata),
        .rd_idx    ('0),
        .rd_data   (refill_beat_unused),
        .line      (o_data_block)
    );

    axi_line_buffer #(
        .BLOCK_WIDTH (BLOCK_WIDTH),
        .DATA_WIDTH  (DATA_WIDTH),
        .IDX_W       (IDX_W)
    ) u_wb_buf (
        .clk       (clk),
        .arstn     (arstn),
        .load_en   (wb_load_c),
        .load_line (i_data_block),
        .wr_en     (1'b0),
        .wr_idx    ('0),
        .wr_data   ('0),
        .rd_idx    (wb_rd_idx_c),
        .rd_data   (wb_beat_c),
        .line      (wb_line_unused)
    );

    // Transaction FSM with registered channel valids/readies and completion pulses.
    always_ff @(posedge clk) begin
        if (!arstn) begin
            state       <= ST_IDLE;
            beat        <= '0;
            addr        <= '0;
            o_arvalid   <= 1'b0;
            o_rready    <= 1'b0;
            o_awvalid   <= 1'b0;
            o_wvalid    <= 1'b0;
            o_wlast     <= 1'b0;
            o_wdata     <= '0;
            o_bready    <= 1'b0;
            o_read_last <= 1'b0;
            o_b_resp    <= 1'b0;
            o_resp_err  <= 1'b0;
        end else begin
            o_read_last <= 1'b0;
            o_b_resp    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_start_write) begin
                        addr      <= i_addr & LINE_MASK;
                        o_awvalid <= 1'b1;
                        state     <= ST_AW;
                    end else if (i_start_read) begin
                        addr      <= i_addr & LINE_MASK;
                        o_arvalid <= 1'b1;
                        state     <= ST_AR;
                    end
                end
                ST_AR: begin
                    if (i_arready) begin
                        o_arvalid <= 1'b0;
                        o_rready  <= 1'b1;
                        beat      <= '0;
                        state     <= ST_R;
                    end
                end
                ST_R: begin
                    if (i_rvalid) begin
                        // Errors are only flagged; completion is by beat count.
                        if ((i_rresp != AXI_RESP_OKAY) || (i_rlast != (beat == LAST_BEAT))) begin
                            o_resp_err <= 1'b1;
                        end
                        if (beat == LAST_BEAT) begin
                            o_rready    <= 1'b0;
                            o_read_last <= 1'b1;
                            beat        <= '0;
                            state       <= ST_R_DONE;
                        end else begin
                            beat <= beat + IDX_W'(1);
                        end
                    end
                end
                ST_R_DONE: begin
                    state <= ST_IDLE;
                end
                ST_AW: begin
                    if (i_awready) begin
                        o_awvalid <= 1'b0;
                        o_wvalid  <= 1'b1;
                        o_wdata   <= wb_beat_c;
                        o_wlast   <= 1'b0;
                        beat      <= '0;
                        state     <= ST_W;
                    end
                end
                ST_W: begin
                    if (i_wready) begin
                        if (beat == LAST_BEAT) begin
                            o_wvalid <= 1'b0;
                            o_wlast  <= 1'b0;
                            o_bready <= 1'b1;
                            beat     <= '0;
                            state    <= ST_B;
                        end else begin
                            beat    <= beat + IDX_W'(1);
                            o_wdata <= wb_beat_c;
                            o_wlast <= ((beat + IDX_W'(1)) == LAST_BEAT);
                        end
                    end
                end
                ST_B: begin
                    if (i_bvalid) begin
                        if (i_bresp != AXI_RESP_OKAY) begin
                            o_resp_err <= 1'b1;
                        end
                        o_bready <= 1'b0;
                        o_b_resp <= 1'b1;
                        state    <= ST_B_DONE;
                    end
                end
                ST_B_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_burst_master.sv
// Randomised bench for axi_burst_master: handshake-level transaction model,
// per-cycle compare process, and literal checks on the directed scenarios.
module tb_axi_burst_master;

    logic         clk;
    logic         arstn;
    logic         i_start_read, i_start_write;
    logic [63:0]  i_addr;
    logic [511:0] i_data_block, o_data_block;
    logic         o_read_last, o_b_resp, o_resp_err;
    logic [3:0]   o_arid, o_awid;
    logic [63:0]  o_araddr, o_awaddr;
    logic [7:0]   o_arlen, o_awlen;
    logic [2:0]   o_arsize, o_awsize;
    logic [1:0]   o_arburst, o_awburst;
    logic         o_arvalid, i_arready;
    logic [63:0]  i_rdata;
    logic [1:0]   i_rresp;
    logic         i_rlast, i_rvalid, o_rready;
    logic         o_awvalid, i_awready;
    logic [63:0]  o_wdata;
    logic [7:0]   o_wstrb;
    logic         o_wlast, o_wvalid, i_wready;
    logic [1:0]   i_bresp;
    logic         i_bvalid, o_bready;

    axi_burst_master dut (
        .clk(clk), .arstn(arstn),
        .i_start_read(i_start_read), .i_start_write(i_start_write),
        .i_addr(i_addr), .i_data_block(i_data_block), .o_data_block(o_data_block),
        .o_read_last(o_read_last), .o_b_resp(o_b_resp), .o_resp_err(o_resp_err),
        .o_arid(o_arid), .o_araddr(o_araddr), .o_arlen(o_arlen), .o_arsize(o_arsize),
        .o_arburst(o_arburst), .o_arvalid(o_arvalid), .i_arready(i_arready),
        .i_rdata(i_rdata), .i_rresp(i_rresp), .i_rlast(i_rlast), .i_rvalid(i_rvalid),
        .o_rready(o_rready),
        .o_awid(o_awid), .o_awaddr(o_awaddr), .o_awlen(o_awlen), .o_awsize(o_awsize),
        .o_awburst(o_awburst), .o_awvalid(o_awvalid), .i_awready(i_awready),
        .o_wdata(o_wdata), .o_wstrb(o_wstrb), .o_wlast(o_wlast), .o_wvalid(o_wvalid),
        .i_wready(i_wready),
        .i_bresp(i_bresp), .i_bvalid(i_bvalid), .o_bready(o_bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- transaction-level model ----------------
    int           ph = 0;           // 0 idle, 1 refill, 2 writeback
    bit           m_arv, m_rr, m_awv, m_wv, m_br, m_rl, m_bp, m_err;
    int           rb = 0, wb = 0;
    logic [63:0]  m_addr = '0;
    logic [511:0] m_rline = '0, m_wline = '0;
    int           n_rl = 0, n_bp = 0;
    logic [63:0]  cap_araddr = '0;
    logic [63:0]  wq_data[$];
    bit           wq_last[$];

    always @(posedge clk) begin
        if (o_read_last) n_rl++;
        if (o_b_resp) n_bp++;
        if (o_arvalid) cap_araddr = o_araddr;
        if (o_wvalid && i_wready) begin
            wq_data.push_back(o_wdata);
            wq_last.push_back(o_wlast);
        end
        if (!arstn) begin
            ph = 0; rb = 0; wb = 0;
            m_arv = 0; m_rr = 0; m_awv = 0; m_wv = 0; m_br = 0;
            m_rl = 0; m_bp = 0; m_err = 0;
            m_addr = '0; m_rline = '0;
        end else if (ph == 0) begin
            if (i_start_write) begin
                ph = 2; m_addr = i_addr & ~64'h3f; m_wline = i_data_block; m_awv = 1;
            end else if (i_start_read) begin
                ph = 1; m_addr = i_addr & ~64'h3f; m_arv = 1;
            end
        end else if (ph == 1) begin
            if (m_rl) begin
                m_rl = 0; ph = 0;
            end else if (m_arv) begin
                if (i_arready) begin m_arv = 0; m_rr = 1; rb = 0; end
            end else if (m_rr && i_rvalid) begin
                m_rline[rb*64 +: 64] = i_rdata;
                if (i_rresp != 2'b00 || i_rlast != (rb == 7)) m_err = 1;
                rb++;
                if (rb == 8) begin m_rr = 0; m_rl = 1; end
            end
        end else begin
            if (m_bp) begin
                m_bp = 0; ph = 0;
            end else if (m_awv) begin
                if (i_awready) begin m_awv = 0; m_wv = 1; wb = 0; end
            end else if (m_wv) begin
                if (i_wready) begin
                    wb++;
                    if (wb == 8) begin m_wv = 0; m_br = 1; end
                end
            end else if (m_br && i_bvalid) begin
                if (i_bresp != 2'b00) m_err = 1;
                m_br = 0; m_bp = 1;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            chk("arvalid", o_arvalid, m_arv);
            chk("rready", o_rready, m_rr);
            chk("awvalid", o_awvalid, m_awv);
            chk("wvalid", o_wvalid, m_wv);
            chk("bready", o_bready, m_br);
            chk("read_last", o_read_last, m_rl);
            chk("b_resp", o_b_resp, m_bp);
            chk("resp_err", o_resp_err, m_err);
            chk("data_block", o_data_block, m_rline);
            if (o_arvalid) begin
                chk("araddr", o_araddr, m_addr);
                chk("ar_fields", {o_arid, o_arlen, o_arsize, o_arburst}, {4'd0, 8'd7, 3'b011, 2'b01});
            end
            if (o_awvalid) begin
                chk("awaddr", o_awaddr, m_addr);
                chk("aw_fields", {o_awid, o_awlen, o_awsize, o_awburst}, {4'd0, 8'd7, 3'b011, 2'b01});
            end
            if (o_wvalid && wb < 8) begin
                chk("wdata", o_wdata, m_wline[wb*64 +: 64]);
                chk("wlast", o_wlast, (wb == 7));
                chk("wstrb", o_wstrb, 8'hff);
            end
        end
    end

    // ---------------- slave responder ----------------
    int          ar_delay = 0, r_prob = 100, w_mode = 0, b_delay = 0;
    int          rresp_bad_beat = -1, rlast_bad_beat = -1;
    bit          aw_fast = 1;
    logic [63:0] beat_data [8];

    initial begin
        int arw = 0;
        int bw  = 0;
        bit tg  = 0;
        i_arready = 0; i_rvalid = 0; i_rdata = '0; i_rresp = 0; i_rlast = 0;
        i_awready = 0; i_wready = 0; i_bvalid = 0; i_bresp = 0;
        forever begin
            @(negedge clk);
            if (!o_arvalid) arw = 0;
            i_arready = o_arvalid && (arw >= ar_delay);
            if (o_arvalid) arw++;
            i_rvalid = o_rready && ($urandom_range(99) < r_prob);
            if (i_rvalid && rb < 8) begin
                i_rdata = beat_data[rb];
                i_rresp = (rb == rresp_bad_beat) ? 2'b10 : 2'b00;
                i_rlast = (rb == 7) ^ (rb == rlast_bad_beat);
            end else begin
                i_rdata = {$urandom, $urandom};
                i_rresp = 2'b00;
                i_rlast = 1'b0;
            end
            i_awready = o_awvalid && (aw_fast || ($urandom_range(1) == 1));
            tg = ~tg;
            case (w_mode)
                0: i_wready = o_wvalid;
                1: i_wready = o_wvalid && tg;
                default: i_wready = o_wvalid && ($urandom_range(1) == 1);
            endcase
            if (!o_bready) bw = 0;
            i_bvalid = o_bready && (bw >= b_delay);
            if (o_bready) bw++;
            i_bresp = 2'b00;
        end
    end

    // ---------------- requester tasks ----------------
    task automatic do_req(input bit wr, input logic [63:0] a, output int cycles);
        bit found;
        @(negedge clk);
        i_addr = a;
        if (wr) i_start_write = 1; else i_start_read = 1;
        cycles = 0;
        found  = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            cycles++;
            if (wr ? o_b_resp : o_read_last) begin
                found = 1;
                break;
            end
        end
        i_start_write = 0;
        i_start_read  = 0;
        chk(wr ? "wb_timeout" : "refill_timeout", found, 1'b1);
    endtask

    task automatic pulse_reset();
        @(negedge clk); arstn = 0;
        @(negedge clk); arstn = 1;
    endtask

    task automatic set_zero_wait();
        ar_delay = 0; r_prob = 100; w_mode = 0; b_delay = 0; aw_fast = 1;
        rresp_bad_beat = -1; rlast_bad_beat = -1;
    endtask

    initial begin
        int           cyc;
        int           rl0, bp0;
        logic [511:0] exp_line;
        logic [63:0]  exp_beat;
        bit           found, saw_ar, saw_aw_first;

        arstn = 0; i_start_read = 0; i_start_write = 0; i_addr = '0; i_data_block = '0;
        repeat (2) @(negedge clk);
        chk("rst_arvalid", o_arvalid, 1'b0);
        chk("rst_awvalid", o_awvalid, 1'b0);
        chk("rst_data", o_data_block, 512'd0);
        chk("rst_err", o_resp_err, 1'b0);
        chk("rst_arlen", o_arlen, 8'd7);
        arstn = 1;

        // Zero-wait refill
        set_zero_wait();
        for (int k = 0; k < 8; k++) beat_data[k] = 64'(k);
        rl0 = n_rl;
        do_req(0, 64'h8000_1234, cyc);
        chk("refill_latency", cyc, 10);
        chk("araddr_lit", cap_araddr, 64'h8000_1200);
        for (int k = 0; k < 8; k++) chk("lane_lit", o_data_block[k*64 +: 64], 64'(k));
        @(negedge clk);
        chk("refill_pulses", n_rl - rl0, 1);

        // Writeback with wready toggling
        for (int i = 0; i < 64; i++) i_data_block[i*8 +: 8] = 8'(i);
        w_mode = 1; aw_fast = 0; b_delay = 2;
        wq_data.delete(); wq_last.delete();
        bp0 = n_bp;
        do_req(1, 64'h0000_0000_1000_0040, cyc);
        @(negedge clk);
        chk("wb_beats", wq_data.size(), 8);
        for (int k = 0; k < 8 && k < wq_data.size(); k++) begin
            for (int j = 0; j < 8; j++) exp_beat[j*8 +: 8] = 8'(8*k + j);
            chk("wdata_lit", wq_data[k], exp_beat);
            chk("wlast_lit", wq_last[k], (k == 7));
        end
        chk("wb_pulses", n_bp - bp0, 1);
        chk("data_held", o_data_block[7*64 +: 64], 64'd7);

        // Simultaneous requests: writeback first
        set_zero_wait();
        for (int k = 0; k < 8; k++) beat_data[k] = {$urandom, $urandom};
        i_data_block = {16{$urandom}};
        rl0 = n_rl; bp0 = n_bp; saw_ar = 0; saw_aw_first = 0; found = 0;
        @(negedge clk);
        i_addr = 64'h1234_5678_9abc_def0; i_start_write = 1; i_start_read = 1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (o_arvalid) saw_ar = 1;
            if (o_awvalid && !saw_ar) saw_aw_first = 1;
            if (o_b_resp) begin found = 1; break; end
        end
        chk("both_wb_done", found, 1'b1);
        i_start_write = 0;
        found = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (o_read_last) begin found = 1; break; end
        end
        i_start_read = 0;
        chk("both_read_done", found, 1'b1);
        chk("no_ar_before_b", saw_ar, 1'b0);
        chk("aw_first", saw_aw_first, 1'b1);
        chk("both_araddr", cap_araddr, 64'h1234_5678_9abc_dec0);
        @(negedge clk);
        chk("both_pulses", (n_rl - rl0) * 16 + (n_bp - bp0), 17);

        // Delayed arready, rvalid gaps
        ar_delay = 5; r_prob = 50;
        for (int k = 0; k < 8; k++) beat_data[k] = {$urandom, $urandom};
        rl0 = n_rl;
        do_req(0, 64'hdead_beef_0000_0aff, cyc);
        for (int k = 0; k < 8; k++) exp_line[k*64 +: 64] = beat_data[k];
        chk("gap_line", o_data_block, exp_line);
        @(negedge clk);
        chk("gap_pulses", n_rl - rl0, 1);

        // SLVERR on beat 3
        set_zero_wait();
        rresp_bad_beat = 3;
        do_req(0, 64'h40, cyc);
        chk("slverr_latency", cyc, 10);
        repeat (3) @(negedge clk);
        chk("slverr_sticky", o_resp_err, 1'b1);
        pulse_reset();
        chk("err_cleared", o_resp_err, 1'b0);

        // Early rlast on beat 5
        set_zero_wait();
        rlast_bad_beat = 5;
        do_req(0, 64'h80, cyc);
        chk("rlast_latency", cyc, 10);
        repeat (2) @(negedge clk);
        chk("rlast_sticky", o_resp_err, 1'b1);
        pulse_reset();

        // Reset during beat 4
        set_zero_wait();
        for (int k = 0; k < 8; k++) beat_data[k] = 64'hA5A5_0000_0000_0000 | 64'(k);
        @(negedge clk);
        i_addr = 64'h2000; i_start_read = 1;
        found = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (rb == 4 && o_rready) begin found = 1; break; end
        end
        chk("reach_beat4", found, 1'b1);
        arstn = 0; i_start_read = 0;
        @(negedge clk);
        chk("mid_rst_rready", o_rready, 1'b0);
        chk("mid_rst_pulse", o_read_last, 1'b0);
        chk("mid_rst_data", o_data_block, 512'd0);
        arstn = 1;
        for (int k = 0; k < 8; k++) beat_data[k] = {$urandom, $urandom};
        do_req(0, 64'h3000, cyc);
        chk("post_rst_latency", cyc, 10);
        for (int k = 0; k < 8; k++) exp_line[k*64 +: 64] = beat_data[k];
        chk("post_rst_line", o_data_block, exp_line);

        // Random mix
        for (int t = 0; t < 12; t++) begin
            ar_delay = $urandom_range(3); r_prob = $urandom_range(30, 100);
            w_mode = $urandom_range(2); b_delay = $urandom_range(3);
            aw_fast = ($urandom_range(1) == 1);
            rresp_bad_beat = -1; rlast_bad_beat = -1;
            for (int k = 0; k < 8; k++) beat_data[k] = {$urandom, $urandom};
            for (int k = 0; k < 16; k++) i_data_block[k*32 +: 32] = $urandom;
            do_req($urandom_range(1) == 1, {$urandom, $urandom}, cyc);
        end
        repeat (3) @(negedge clk);
        chk("final_err_clear", o_resp_err, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
